// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch channel between fetch_unit and instruction memory.
// The fetch unit drives req/addr (master); memory returns ack/rdata (slave).
interface fetch_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch / program-counter stage.
// FETCH issues a word read at pc and waits for ack; EXEC presents the latched
// instruction to control until it retires; TRAP parks the unit after a
// misaligned jr until reset.
// Optional macro FETCH_PERF_CNT_EN adds retired-instruction and stall counters.
module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pcsrc,
    input  logic [WIDTH-1:0]  jr_target,
    input  logic              stall,
    fetch_unit_if.master      imem,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [5:0]        op,
    output logic [5:0]        func,
    output logic [WIDTH-1:0]  pc,
    output logic [WIDTH-1:0]  pc_plus4,
    output logic              trap
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       instret_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_TRAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic             trap_q, trap_d;

    logic [WIDTH-1:0] branch_off;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] next_pc;
    logic             retire;
    logic             jr_misaligned;

    assign pc_plus4      = pc_q + {{(WIDTH-3){1'b0}}, 3'd4};
    assign branch_off    = {{(WIDTH-18){inst_q[15]}}, inst_q[15:0], 2'b00};
    assign branch_target = pc_plus4 + branch_off;

    // Jump target keeps the region bits above bit 27 only when they exist.
    generate
        if (WIDTH > 28) begin : g_jump_region
            assign jump_target = {pc_plus4[WIDTH-1:28], inst_q[25:0], 2'b00};
        end else begin : g_jump_flat
            assign jump_target = {inst_q[25:0], 2'b00};
        end
    endgenerate

    // Next-PC select; only consumed when an EXEC-state instruction retires.
    always_comb begin
        next_pc = pc_plus4;
        case (pcsrc)
            2'b00:   next_pc = pc_plus4;
            2'b01:   next_pc = branch_target;
            2'b10:   next_pc = jr_target;
            default: next_pc = jump_target;
        endcase
    end

    assign retire        = (state_q == S_EXEC) && !stall;
    assign jr_misaligned = (pcsrc == 2'b10) && (jr_target[1:0] != 2'b00);

    // FSM next-state: fetch/capture, hold on stall, commit PC or trap on retire.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        trap_d  = trap_q;
        case (state_q)
            S_FETCH: begin
                if (imem.imem_ack) begin
                    inst_d  = imem.imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (retire) begin
                    if (jr_misaligned) begin
                        trap_d  = 1'b1;
                        state_d = S_TRAP;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    // State registers; reset abandons any outstanding fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            trap_q  <= trap_d;
        end
    end

    // Request is decoded purely from state (no path from pcsrc/stall) and
    // is forced low while reset is held.
    assign imem.imem_req  = (state_q == S_FETCH) && !rst;
    assign imem.imem_addr = pc_q;

    assign inst_valid = (state_q == S_EXEC);
    assign inst       = inst_q;
    assign op         = inst_q[31:26];
    assign func       = inst_q[5:0];
    assign pc         = pc_q;
    assign trap       = trap_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] instret_cnt_q, instret_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counters: retired instructions (trapping jr excluded) and lost cycles.
    always_comb begin
        instret_cnt_d = instret_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        if (retire && !jr_misaligned) begin
            instret_cnt_d = instret_cnt_q + 32'd1;
        end
        if (((state_q == S_EXEC) && stall) ||
            ((state_q == S_FETCH) && !imem.imem_ack)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counter registers, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            instret_cnt_q <= instret_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign instret_cnt = instret_cnt_q;
    assign stall_cnt   = stall_cnt_q;
`endif

endmodule
